// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: register IDs, data width and instruction codes.
package y86_pkg;

  localparam int unsigned DW   = 64;
  localparam int unsigned NREG = 15;

  typedef logic [3:0] reg_id_t;

  localparam reg_id_t RRSP  = 4'h4;
  localparam reg_id_t RNONE = 4'hF;

  typedef enum logic [3:0] {
    IHalt   = 4'h0,
    INop    = 4'h1,
    IRrmovq = 4'h2,
    IIrmovq = 4'h3,
    IRmmovq = 4'h4,
    IMrmovq = 4'h5,
    IOpq    = 4'h6,
    IJxx    = 4'h7,
    ICall   = 4'h8,
    IRet    = 4'h9,
    IPushq  = 4'hA,
    IPopq   = 4'hB
  } icode_e;

  function automatic logic is_reg(reg_id_t id);
    return id != RNONE;
  endfunction

endpackage

// File: rtl/y86_rf_readport.sv
// One register-file read port: ID-to-data mux, ID 0xF reads zero.
// With RF_BYPASS_EN defined, same-cycle write data is forwarded (M over E).
module y86_rf_readport
  import y86_pkg::*;
#(
  parameter int unsigned DW   = 64,
  parameter int unsigned NREG = 15
) (
  input  logic [DW-1:0] rf_i [NREG],
  input  reg_id_t       sel_i,
  input  logic          byp_en_i,
  input  logic          wb_en_i,
  input  reg_id_t       dst_e_i,
  input  reg_id_t       dst_m_i,
  input  logic [DW-1:0] val_e_i,
  input  logic [DW-1:0] val_m_i,
  output logic [DW-1:0] val_o
);

  always_comb begin
    val_o = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (sel_i == reg_id_t'(i)) val_o = rf_i[i];
    end
`ifdef RF_BYPASS_EN
    if (byp_en_i && wb_en_i && is_reg(sel_i)) begin
      if (sel_i == dst_m_i) begin
        val_o = val_m_i;
      end else if (sel_i == dst_e_i) begin
        val_o = val_e_i;
      end
    end
`endif
  end

`ifndef RF_BYPASS_EN
  logic unused_byp;
  assign unused_byp = ^{byp_en_i, wb_en_i, dst_e_i, dst_m_i, val_e_i, val_m_i};
`endif

endmodule

// File: rtl/y86_regfile.sv
// Y86-64 register file: 15 x DW storage, two writes (M wins collisions), three reads.
// Optional write-through forwarding on valA/valB when RF_BYPASS_EN is defined.
module y86_regfile
  import y86_pkg::*;
#(
  parameter int unsigned       DW       = 64,
  parameter logic [DW-1:0]     RSP_INIT = '0,
  parameter int unsigned       NREG     = 15
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  reg_id_t       src_a_i,
  input  reg_id_t       src_b_i,
  input  reg_id_t       dst_e_i,
  input  reg_id_t       dst_m_i,
  input  logic [DW-1:0] val_e_i,
  input  logic [DW-1:0] val_m_i,
  input  logic          wb_en_i,
  input  reg_id_t       dbg_sel_i,
  output logic [DW-1:0] val_a_o,
  output logic [DW-1:0] val_b_o,
  output logic [DW-1:0] dbg_val_o,
  output logic [15:0]   wr_count_o
);

  logic [DW-1:0] rf_q [NREG];
  logic [DW-1:0] rf_d [NREG];
  logic [15:0]   wr_count_q, wr_count_d;
  logic          commit;

  always_comb begin
    rf_d = rf_q;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (wb_en_i) begin
        // Port M checked first so it wins a same-register collision (popq %rsp).
        if (dst_m_i == reg_id_t'(i)) begin
          rf_d[i] = val_m_i;
        end else if (dst_e_i == reg_id_t'(i)) begin
          rf_d[i] = val_e_i;
        end
      end
    end
  end

  assign commit     = wb_en_i && (is_reg(dst_e_i) || is_reg(dst_m_i));
  assign wr_count_d = (commit && (wr_count_q != 16'hFFFF)) ? wr_count_q + 16'd1 : wr_count_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        rf_q[i] <= (reg_id_t'(i) == RRSP) ? RSP_INIT : '0;
      end
      wr_count_q <= '0;
    end else begin
      rf_q       <= rf_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign wr_count_o = wr_count_q;

  y86_rf_readport #(.DW(DW), .NREG(NREG)) u_port_a (
    .rf_i     (rf_q),
    .sel_i    (src_a_i),
    .byp_en_i (1'b1),
    .wb_en_i  (wb_en_i),
    .dst_e_i  (dst_e_i),
    .dst_m_i  (dst_m_i),
    .val_e_i  (val_e_i),
    .val_m_i  (val_m_i),
    .val_o    (val_a_o)
  );

  y86_rf_readport #(.DW(DW), .NREG(NREG)) u_port_b (
    .rf_i     (rf_q),
    .sel_i    (src_b_i),
    .byp_en_i (1'b1),
    .wb_en_i  (wb_en_i),
    .dst_e_i  (dst_e_i),
    .dst_m_i  (dst_m_i),
    .val_e_i  (val_e_i),
    .val_m_i  (val_m_i),
    .val_o    (val_b_o)
  );

  // The debug port always observes storage only.
  y86_rf_readport #(.DW(DW), .NREG(NREG)) u_port_dbg (
    .rf_i     (rf_q),
    .sel_i    (dbg_sel_i),
    .byp_en_i (1'b0),
    .wb_en_i  (wb_en_i),
    .dst_e_i  (dst_e_i),
    .dst_m_i  (dst_m_i),
    .val_e_i  (val_e_i),
    .val_m_i  (val_m_i),
    .val_o    (dbg_val_o)
  );

endmodule

// File: doc/y86_regfile.md
Name: y86_regfile

Overview:
- Y86-64 architectural register file; sits directly downstream of the decode/writeback ID-selection logic.
- Consumes srcA/srcB (read IDs) and dstE/dstM (write IDs) from that stage; supplies valA/valB to execute.
- Accepts valE (ALU result) and valM (memory data) for write-back at the clock edge.
- Holds 15 64-bit registers (IDs 0x0-0xE); ID 0xF means "no register".

Parameters:
- DW, 64, register data width.
- RSP_INIT, 64'h0, reset value of register 0x4 (%rsp); all other registers reset to 0.
- NREG, 15, number of architectural registers (fixed by ISA; must be 15).

Ports:
- clk  input  1  single clock; all register updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- srcA  input  4  read port A register ID; 0xF = none.
- srcB  input  4  read port B register ID; 0xF = none.
- dstE  input  4  write port E register ID; 0xF = no write.
- dstM  input  4  write port M register ID; 0xF = no write.
- valE  input  DW  write data for port E.
- valM  input  DW  write data for port M.
- wb_en  input  1  global write-back enable; 0 suppresses both writes (halt/exception freeze).
- dbg_sel  input  4  debug read-port register ID.
- valA  output  DW  contents of srcA.
- valB  output  DW  contents of srcB.
- dbg_val  output  DW  contents of dbg_sel.
- wr_count  output  16  count of committed write-back cycles (saturating).

Behaviour:
- Reset (async, active-high): all registers cleared to 0 except %rsp (0x4), which loads RSP_INIT. wr_count is cleared to 0.
- Reset asserted mid-cycle overrides any write pending for that edge.
- Reads: valA, valB and dbg_val are combinational from current storage, with zero latency.
- Read ID 0xF returns 0.
- Writes occur at the rising clk edge, only when reset=0 and wb_en=1.
  - Port E writes valE to dstE if dstE != 0xF.
  - Port M writes valM to dstM if dstM != 0xF.
- Collision (dstE == dstM, both != 0xF): port M wins; the register takes valM. This matches popq %rsp semantics.
- wb_en=0: storage is unchanged regardless of dstE/dstM.
- Read-during-write, same cycle: without bypass, the read returns the old value. The new value is visible the cycle after the edge.
- wr_count increments by 1 on each edge where at least one write commits.
  - A dual write counts once.
  - Saturates at 16'hFFFF; no wrap.
- No internal FSM beyond storage and the counter.
- All widths are exact; no sign extension is performed.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: write-through forwarding on valA and valB (dbg_val excluded).
  - If wb_en=1 and srcX matches dstM (!=0xF), valX = valM.
  - Otherwise, if srcX matches dstE (!=0xF), valX = valE.
  - M priority mirrors the collision rule.
- Undefined: no forwarding; reads are storage-only as described above.

Decomposition:
- Shared package y86_pkg:
  - Register ID constants: RRSP=4'h4, RNONE=4'hF.
  - DW, and a reg_id_t 4-bit typedef.
  - Icode constants reused by decode.
- One natural sub-module: y86_rf_readport (ID to data mux with 0xF to zero, optional bypass), instantiated three times (A, B, debug).
- Storage and write logic stay in the top.

Test Plan:
- Reset with RSP_INIT=64'h200 -> dbg_sel=4 reads 0x200; dbg_sel=0..3,5..E read 0; wr_count=0.
- dstE=3, valE=0x1234, wb_en=1, one edge -> after edge srcA=3 gives valA=0x1234; wr_count=1.
- dstE=4, valE=0x1F8, dstM=4, valM=0xABCD, same edge -> %rsp=0xABCD; wr_count increments by exactly 1.
- wb_en=0, dstE=2, valE=0x55 -> register 2 unchanged; wr_count unchanged. srcA=0xF -> valA=0.
- srcA=dstE=7, valE=0x99, old r7=0x11, before edge:
  - RF_BYPASS_EN undefined: valA=0x11.
  - RF_BYPASS_EN defined: valA=0x99.
- Assert reset asynchronously between edges after writes -> all outputs return to reset values immediately.
- Force 65535 write cycles plus one more -> wr_count holds 0xFFFF.
